// File: rtl/click_ctrl.sv
// -----------------------------------------------------------------------------
// click_ctrl
//
// Button front-end controller for a step counter. A short press either emits a
// single manual step or, in auto-click mode, advances the auto-click rate. A
// long press (held for LONG time-base ticks) toggles between manual and
// auto-click mode. In auto-click mode a free-running tick counter emits a step
// every rate_o+1 ticks.
//
// Build option:
//   CLICK_CTRL_STEP_CNT_EN  adds step_cnt_o, a 16-bit wrapping count of step_o
//                           pulses. When undefined the port and its logic are
//                           absent.
//
// Parameters:
//   W     width of the auto-click rate selector
//   LONG  long-press threshold in tick_i strobes (2..255)
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   press_i     one-cycle debounced press-down pulse
//   held_i      debounced button level (1 = pressed)
//   tick_i      one-cycle prescaled time-base strobe
//   step_o      registered one-cycle step pulse
//   auto_o      mode: 1 = auto-click, 0 = manual
//   rate_o      auto-click period selector (period = rate_o+1 ticks)
//   step_cnt_o  (optional) count of step_o pulses
//
// FSM states:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a press_i pulse
//   TIMING    | button down, counting held ticks toward the long threshold
//   LONG_WAIT | long press already acted on, waiting for release
// -----------------------------------------------------------------------------
module click_ctrl #(
  parameter int W    = 3,
  parameter int LONG = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         press_i,
  input  logic         held_i,
  input  logic         tick_i,
  output logic         step_o,
  output logic         auto_o,
  output logic [W-1:0] rate_o
`ifdef CLICK_CTRL_STEP_CNT_EN
  ,
  output logic [15:0]  step_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TIMING    = 2'd1,
    LONG_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] LONG_C = 8'(LONG);

  state_e         state_q, state_d;
  logic [7:0]     hold_q,  hold_d;
  logic           auto_q,  auto_d;
  logic [W-1:0]   rate_q,  rate_d;
  logic [W-1:0]   tick_q,  tick_d;
  logic           step_q,  step_d;

  logic           manual_step;
  logic           auto_step;
  logic           rate_chg;
  logic           auto_enter;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      auto_q  <= 1'b0;
      rate_q  <= '0;
      tick_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      auto_q  <= auto_d;
      rate_q  <= rate_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Press FSM: classifies presses and updates mode / rate
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    auto_d      = auto_q;
    rate_d      = rate_q;
    manual_step = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (press_i) begin
          state_d = TIMING;
          hold_d  = '0;
        end
      end

      TIMING: begin
        // Release wins over a coincident tick: a tick only counts while held.
        if (!held_i) begin
          state_d = IDLE;
          if (auto_q) begin
            rate_d = rate_q + W'(1);
          end else begin
            manual_step = 1'b1;
          end
        end else if (tick_i) begin
          hold_d = hold_q + 8'd1;
          if (hold_q + 8'd1 == LONG_C) begin
            auto_d  = ~auto_q;
            state_d = LONG_WAIT;
          end
        end
      end

      LONG_WAIT: begin
        if (!held_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Auto-click timer
  // ---------------------------------------------------------------------------
  assign rate_chg   = (rate_d != rate_q);
  assign auto_enter = auto_d & ~auto_q;

  always_comb begin
    tick_d    = tick_q;
    auto_step = 1'b0;

    // A rate change or fresh entry into auto mode restarts the period and
    // drops any step that would have landed this cycle. Stepping requires
    // auto mode both now and next cycle, so the leaving cycle emits nothing.
    if (auto_enter || rate_chg) begin
      tick_d = '0;
    end else if (auto_q && auto_d && tick_i) begin
      if (tick_q == rate_q) begin
        auto_step = 1'b1;
        tick_d    = '0;
      end else begin
        tick_d = tick_q + W'(1);
      end
    end
  end

  // Manual and auto steps are mutually exclusive by mode. The step_q term only
  // matters if tick_i were ever high on consecutive cycles at rate 0; it keeps
  // step_o a strict single-cycle pulse.
  assign step_d = (manual_step | auto_step) & ~step_q;

  assign step_o = step_q;
  assign auto_o = auto_q;
  assign rate_o = rate_q;

`ifdef CLICK_CTRL_STEP_CNT_EN
  // ---------------------------------------------------------------------------
  // Step counter: advances on the same edge that raises step_o
  // ---------------------------------------------------------------------------
  logic [15:0] step_cnt_q, step_cnt_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (step_d) begin
      step_cnt_d = step_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step_cnt_o = step_cnt_q;
`endif

endmodule

// File: tb/tb_click_ctrl.sv
// -----------------------------------------------------------------------------
// tb_click_ctrl
//
// Directed, cycle-by-cycle bench for click_ctrl with LONG=4, W=3. Each applied
// cycle carries hand-computed expectations for step/auto/rate sampled 1 ns
// after the rising edge. A vector table covers manual steps, entry into auto
// mode, rate increments and wrap; hand-written sequences cover reset during
// an auto period and leaving auto mode.
// -----------------------------------------------------------------------------
module tb_click_ctrl;

  logic       clk;
  logic       rst;
  logic       press;
  logic       held;
  logic       tick;
  logic       step;
  logic       auto_m;
  logic [2:0] rate;
`ifdef CLICK_CTRL_STEP_CNT_EN
  logic [15:0] step_cnt;
`endif

  int checks = 0;
  int errors = 0;

  click_ctrl #(.W(3), .LONG(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .press_i    (press),
    .held_i     (held),
    .tick_i     (tick),
    .step_o     (step),
    .auto_o     (auto_m),
    .rate_o     (rate)
`ifdef CLICK_CTRL_STEP_CNT_EN
    ,
    .step_cnt_o (step_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       p;
    logic       h;
    logic       t;
    logic       s;
    logic       a;
    logic [2:0] r;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic p, input logic h, input logic t,
                              input logic s, input logic a, input logic [2:0] r);
    vec_t v;
    v.p = p; v.h = h; v.t = t; v.s = s; v.a = a; v.r = r;
    vecs.push_back(v);
  endfunction

  // Apply one cycle of inputs and compare the registered outputs after the edge.
  task automatic cyc(input logic p, input logic h, input logic t,
                     input logic s, input logic a, input logic [2:0] r,
                     input string nm);
    press = p;
    held  = h;
    tick  = t;
    @(posedge clk);
    #1;
    checks++;
    if ({step, auto_m, rate} !== {s, a, r}) begin
      errors++;
      $display("FAIL %s: step/auto/rate got %0b/%0b/%0d want %0b/%0b/%0d",
               nm, step, auto_m, rate, s, a, r);
    end
  endtask

  initial begin
    rst   = 1'b1;
    press = 1'b0;
    held  = 1'b0;
    tick  = 1'b0;

    // ---------------- vector table ----------------
    // manual short press: one step, mode/rate unchanged
    add(1,1,0, 0,0,0);
    add(0,1,1, 0,0,0);
    add(0,1,0, 0,0,0);
    add(0,1,1, 0,0,0);
    add(0,0,0, 1,0,0);
    add(0,0,0, 0,0,0);
    // long press: 4 ticks toggles to auto, no step on the toggle
    add(1,1,0, 0,0,0);
    add(0,1,1, 0,0,0);
    add(0,1,0, 0,0,0);
    add(0,1,1, 0,0,0);
    add(0,1,0, 0,0,0);
    add(0,1,1, 0,0,0);
    add(0,1,0, 0,0,0);
    add(0,1,1, 0,1,0);
    // press ignored in LONG_WAIT; rate 0 => step on every tick, still held
    add(1,1,0, 0,1,0);
    add(0,1,1, 1,1,0);
    add(0,1,0, 0,1,0);
    add(0,1,1, 1,1,0);
    add(0,0,0, 0,1,0);
    add(0,0,1, 1,1,0);
    add(0,0,0, 0,1,0);
    // three short presses in auto: rate 1,2,3, no steps
    for (int k = 1; k <= 3; k++) begin
      add(1,1,0, 0,1,3'(k-1));
      add(0,0,0, 0,1,3'(k));
    end
    // rate 3: a step on every 4th tick
    for (int k = 1; k <= 8; k++) begin
      add(0,0,1, (k % 4 == 0), 1, 3'd3);
      add(0,0,0, 0,1,3'd3);
    end
    // five more presses: 4,5,6,7,0 (wrap)
    for (int k = 4; k <= 8; k++) begin
      add(1,1,0, 0,1,3'(k-1));
      add(0,0,0, 0,1,3'(k % 8));
    end
    add(0,0,1, 1,1,0);
    add(0,0,0, 0,1,0);
    add(0,0,1, 1,1,0);

    // ---------------- reset state ----------------
    @(posedge clk);
    #1;
    checks++;
    if ({step, auto_m, rate} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: step/auto/rate got %0b/%0b/%0d want 0/0/0",
               step, auto_m, rate);
    end
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].p, vecs[i].h, vecs[i].t, vecs[i].s, vecs[i].a, vecs[i].r,
          $sformatf("vec%0d", i));
    end

    // ---------------- reset mid-period, button held ----------------
    for (int k = 1; k <= 5; k++) begin
      cyc(1,1,0, 0,1,3'(k-1), "to_rate5_press");
      cyc(0,0,0, 0,1,3'(k),   "to_rate5_rel");
    end
    cyc(1,1,0, 0,1,3'd5, "mid_press");
    cyc(0,1,1, 0,1,3'd5, "mid_tick1");
    cyc(0,1,0, 0,1,3'd5, "mid_idle");
    cyc(0,1,1, 0,1,3'd5, "mid_tick2");
    rst = 1'b1;
    cyc(0,1,1, 0,0,3'd0, "rst_mid");
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(0,1,1'(k % 2), 0,0,3'd0, "held_after_rst");
    end
    cyc(0,0,0, 0,0,3'd0, "release_after_rst");
    cyc(1,1,0, 0,0,3'd0, "new_press");
    cyc(0,0,0, 1,0,3'd0, "new_press_step");
    cyc(0,0,0, 0,0,3'd0, "new_press_after");

    // ---------------- long press leaves auto mode ----------------
    cyc(1,1,0, 0,0,3'd0, "lp_press");
    for (int k = 1; k <= 3; k++) cyc(0,1,1, 0,0,3'd0, "lp_tick");
    cyc(0,1,1, 0,1,3'd0, "lp_enter_auto");
    cyc(0,0,0, 0,1,3'd0, "lp_release");
    for (int k = 1; k <= 3; k++) begin
      cyc(1,1,0, 0,1,3'(k-1), "rate3_press");
      cyc(0,0,0, 0,1,3'(k),   "rate3_rel");
    end
    // tick counter reaches 3 exactly on the toggling tick: that step is dropped
    cyc(1,1,0, 0,1,3'd3, "leave_press");
    for (int k = 1; k <= 3; k++) begin
      cyc(0,1,1, 0,1,3'd3, "leave_tick");
      cyc(0,1,0, 0,1,3'd3, "leave_gap");
    end
    cyc(0,1,1, 0,0,3'd3, "leave_toggle");
    for (int k = 0; k < 4; k++) cyc(0,1,1'(k % 2), 0,0,3'd3, "leave_held");
    cyc(0,0,0, 0,0,3'd3, "leave_release");
    for (int k = 0; k < 10; k++) cyc(0,0,1'(k % 2), 0,0,3'd3, "manual_ticks");

`ifdef CLICK_CTRL_STEP_CNT_EN
    // ---------------- step counter ----------------
    rst = 1'b1;
    cyc(0,0,0, 0,0,3'd0, "cnt_rst");
    rst = 1'b0;
    checks++;
    if (step_cnt !== 16'd0) begin
      errors++;
      $display("FAIL step_cnt_reset: got %0d want 0", step_cnt);
    end
    for (int k = 0; k < 10; k++) begin
      cyc(1,1,0, 0,0,3'd0, "cnt_press");
      cyc(0,0,0, 1,0,3'd0, "cnt_step");
    end
    cyc(0,0,0, 0,0,3'd0, "cnt_idle");
    checks++;
    if (step_cnt !== 16'd10) begin
      errors++;
      $display("FAIL step_cnt_10: got %0d want 10", step_cnt);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
